// File: rtl/quant_leaky_pack.sv
// Requantizing leaky-ReLU stage that packs eight uint8 channels per 64-bit word
// and buffers finished words in a 4-deep first-word-fall-through FIFO.
module quant_leaky_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        leaky_en,
  input  logic [15:0] scale,
  input  logic [4:0]  shift,
  input  logic [7:0]  zero_point,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        overflow
);

  logic               s1_valid, s1_last;
  logic signed [31:0] s1_a;
  logic        [15:0] s1_scale;
  logic        [4:0]  s1_shift;
  logic        [7:0]  s1_zp;

  logic               s2_valid, s2_last;
  logic signed [47:0] s2_p;
  logic        [4:0]  s2_shift;
  logic        [7:0]  s2_zp;

  logic               s3_valid, s3_last;
  logic        [7:0]  s3_byte;

  logic signed [35:0] leak_prod, leak_shift;
  logic signed [31:0] act;
  logic signed [47:0] a_ext, sc_ext, prod;
  logic signed [48:0] rnd, rsum, rshift;
  logic signed [49:0] q;
  logic        [7:0]  sat_byte;

  // Arithmetic for all three stages; widths are chosen so nothing can wrap.
  always_comb begin
    leak_prod  = $signed(in_data) * 36'sd13;
    leak_shift = leak_prod >>> 7;
    act        = (leaky_en && in_data[31]) ? leak_shift[31:0] : $signed(in_data);

    a_ext  = {{16{s1_a[31]}}, s1_a};
    sc_ext = $signed({32'd0, s1_scale});
    prod   = a_ext * sc_ext;

    rnd = '0;
    if (s2_shift != 5'd0) rnd[s2_shift - 5'd1] = 1'b1;
    rsum   = {s2_p[47], s2_p} + rnd;
    rshift = rsum >>> s2_shift;
    q      = {rshift[48], rshift} + $signed({42'd0, s2_zp});
    if (q[49])              sat_byte = 8'h00;
    else if (q > 50'sd255)  sat_byte = 8'hff;
    else                    sat_byte = q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_a <= '0;
      s1_scale <= '0;   s1_shift <= '0;  s1_zp <= '0;
      s2_valid <= 1'b0; s2_last <= 1'b0; s2_p <= '0;
      s2_shift <= '0;   s2_zp <= '0;
      s3_valid <= 1'b0; s3_last <= 1'b0; s3_byte <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        s1_a     <= act;
        s1_scale <= scale;
        s1_shift <= shift;
        s1_zp    <= zero_point;
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_p     <= prod;
        s2_shift <= s1_shift;
        s2_zp    <= s1_zp;
      end
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      if (s2_valid) s3_byte <= sat_byte;
    end
  end

  logic [2:0]  lane;
  logic [63:0] part_word, word_next;
  logic        word_done;
  logic [64:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        pop, push, full;

  // The partial word only ever holds lanes below the counter, so an early
  // in_last closes the word with the upper lanes already zero.
  always_comb begin
    word_next = part_word;
    word_next[{lane, 3'b000} +: 8] = s3_byte;
    word_done = s3_valid && (s3_last || lane == 3'd7);
    full      = (count == 3'd4);
    out_valid = (count != 3'd0);
    pop       = out_valid && out_ready;
    push      = word_done && (!full || pop);
    out_data  = mem[rd_ptr][63:0];
    out_last  = mem[rd_ptr][64];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= '0;
      part_word <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (s3_valid) begin
        if (word_done) begin
          lane      <= '0;
          part_word <= '0;
        end else begin
          lane      <= lane + 3'd1;
          part_word <= word_next;
        end
      end
      if (push) begin
        mem[wr_ptr] <= {s3_last, word_next};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (word_done && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quant_leaky_pack.sv
// Scoreboard bench for quant_leaky_pack: a behavioural byte model predicts every
// packed word, and a monitor compares each popped word in order.
module tb_quant_leaky_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, leaky_en, out_ready;
  logic [31:0] in_data;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zero_point;
  logic        out_valid, out_last, overflow;
  logic [63:0] out_data;

  always #5 clk = ~clk;

  quant_leaky_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .leaky_en(leaky_en), .scale(scale), .shift(shift), .zero_point(zero_point),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow)
  );

  logic [64:0] exp_q[$];
  logic [63:0] m_part;
  int          m_lane;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [7:0] model_byte(input longint x, input bit leaky,
                                            input longint sc, input int sh, input longint zp);
    longint a, p, r, q;
    a = x;
    if (leaky && x < 0) a = (a * 13) >>> 7;
    p = a * sc;
    r = (p + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0))) >>> sh;
    q = r + zp;
    if (q < 0)   return 8'h00;
    if (q > 255) return 8'hff;
    return q[7:0];
  endfunction

  task automatic send(input int x, input bit last, input bit leaky,
                      input int sc, input int sh, input int zp);
    in_valid   = 1'b1;
    in_data    = x;
    in_last    = last;
    leaky_en   = leaky;
    scale      = sc[15:0];
    shift      = sh[4:0];
    zero_point = zp[7:0];
    m_part[m_lane*8 +: 8] = model_byte(longint'(x), leaky, longint'(sc[15:0]), sh, longint'(zp[7:0]));
    if (last || m_lane == 7) begin
      exp_q.push_back({last, m_part});
      m_part = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Every accepted word is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pop_unexpected: got last=%b data=%h, required no word", out_last, out_data);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          miscompares++;
          $display("[TB] FAIL word: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, e[64], e[63:0]);
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d words pending, out_valid=%b, required 0 and 0", exp_q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_last, overflow, out_data} !== 67'd0) begin
      miscompares++;
      $display("[TB] FAIL reset: got valid=%b last=%b ovf=%b data=%h, required all zero",
               out_valid, out_last, overflow, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity_latency;
    for (int i = 0; i < 8; i++) send(i, 1'b0, 1'b0, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL latency_early: got out_valid=%b in cycle N+3, required 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 64'h0706050403020100 || out_last !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL identity: got valid=%b last=%b data=%h, required 1 0 0706050403020100",
               out_valid, out_last, out_data);
    end
    wait_drain(50);
  endtask

  task automatic test_leaky_round_clamp;
    send(-100,  1'b0, 1'b1, 1,     0,  128);
    send(50,    1'b0, 1'b1, 1,     0,  128);
    send(3,     1'b0, 1'b0, 1,     1,  0);
    send(1000,  1'b0, 1'b0, 1,     0,  0);
    send(-5,    1'b0, 1'b0, 1,     0,  0);
    send(32'h8000_0000, 1'b0, 1'b1, 65535, 31, 255);
    send(32'h7fff_ffff, 1'b0, 1'b0, 65535, 31, 200);
    send(-7,    1'b0, 1'b1, 300,   3,  90);
    for (int i = 0; i < 20; i++)
      send(int'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 255)));
    send(1, 1'b1, 1'b0, 1, 0, 0);
    wait_drain(100);
  endtask

  task automatic test_partial_flush;
    send(32'h11, 1'b0, 1'b0, 1, 0, 0);
    send(32'h22, 1'b0, 1'b0, 1, 0, 0);
    send(32'h33, 1'b1, 1'b0, 1, 0, 0);
    vectors++;
    if (exp_q[0] !== {1'b1, 64'h0000000000332211}) begin
      miscompares++;
      $display("[TB] FAIL flush_model: got %h, required 1_0000000000332211", exp_q[0]);
    end
    for (int i = 0; i < 8; i++) send(i + 8, 1'b0, 1'b0, 1, 0, 0);
    wait_drain(50);
  endtask

  task automatic test_bubbles;
    for (int i = 0; i < 11; i++) begin
      send(i * 9, (i == 10), 1'b0, 2, 1, 5);
      idle(i % 3);
    end
    wait_drain(60);
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int w = 0; w < 5; w++)
      for (int l = 0; l < 8; l++) send(w * 16 + l, 1'b0, 1'b0, 1, 0, 0);
    void'(exp_q.pop_back());
    idle(6);
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_set: got ovf=%b valid=%b, required 1 1", overflow, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_data !== exp_q[0][63:0] || out_last !== exp_q[0][64]) begin
        miscompares++;
        $display("[TB] FAIL stall_stable: got %h, required %h", out_data, exp_q[0][63:0]);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(40);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_reset_midword;
    send(1, 1'b0, 1'b0, 1, 0, 0);
    send(2, 1'b0, 1'b0, 1, 0, 0);
    send(3, 1'b0, 1'b0, 1, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    m_part = '0;
    m_lane = 0;
    for (int i = 0; i < 8; i++) send(i, 1'b0, 1'b0, 1, 0, 0);
    wait_drain(50);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_overflow: got %b, required 0", overflow);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; leaky_en = 1'b0;
    scale = '0; shift = '0; zero_point = '0; out_ready = 1'b1;
    m_part = '0; m_lane = 0;
    @(posedge clk); #1;
    test_reset;
    test_identity_latency;
    test_leaky_round_clamp;
    test_partial_flush;
    test_bubbles;
    test_overflow;
    test_reset_midword;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quant_leaky_pack.md
QUANT_LEAKY_PACK -- requirements
Module: quant_leaky_pack

Interface
REQ-001 SHALL have no parameters; lane count fixed at 8 channels per output word, FIFO depth fixed at 4 words.
REQ-002 SHALL have these ports (clock and reset first):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one accumulator value present; no backpressure to the producer.
- in_data  in  32  signed channel accumulator, bias already included.
- in_last  in  1  final channel of the output pixel; qualified by in_valid.
- leaky_en  in  1  1 = leaky ReLU, 0 = linear.
- scale  in  16  unsigned requant multiplier.
- shift  in  5  right-shift amount, 0..31.
- zero_point  in  8  unsigned output offset.
- out_valid  out  1  packed word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  64  packed uint8 pixel, channel k at bits [k*8 +: 8].
- out_last  out  1  word was closed by in_last.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
REQ-003 Reset rst SHALL be synchronous and active-high; clock clk; all state SHALL update on the rising edge of clk.

Function
REQ-004 leaky_en, scale, shift and zero_point SHALL be sampled with each in_valid and carried down the pipeline with that value, so a configuration change affects only later inputs.
REQ-005 S1 (activation): a = in_data when leaky_en=0 or in_data>=0; otherwise a = (in_data*13) >>> 7, full-width signed arithmetic with floor.
REQ-006 S2 (scale): p = a * scale; scale is zero-extended; the product is a 48-bit signed register.
REQ-007 S3 (round/offset/clamp):
- r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift.
- q = r + zero_point.
- Output byte = 0 if q<0; 255 if q>255; else q[7:0].
- No intermediate wrap is permitted.
REQ-008 Pack: a 3-bit lane counter starting at 0 SHALL place each S3 byte into lane = counter, then increment, wrapping 7->0.
REQ-009 A word SHALL complete when lane 7 is written or a byte tagged in_last is written.
- On in_last, unfilled higher lanes SHALL be 0x00.
- The lane counter SHALL return to 0.
- The word's out_last SHALL be 1.
REQ-010 A completed word SHALL be written into the 4-entry FIFO at the same edge the final byte leaves S3.
REQ-011 Latency: with the FIFO empty, out_valid SHALL be high in cycle N+4, where cycle N is the cycle in which the word's final in_valid is presented.
REQ-012 The FIFO SHALL be first-word-fall-through: out_data and out_last reflect the head entry whenever out_valid=1.
REQ-013 Pop occurs on out_valid & out_ready.
- out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-014 Full FIFO with no pop in the same cycle: the completing word SHALL be discarded, overflow set to 1, and the lane counter reset to 0 as normal.
REQ-015 Full FIFO with a pop in the same cycle: the write SHALL succeed and the count SHALL stay at 4.
REQ-016 Empty FIFO with a write: out_valid SHALL rise the next cycle; there is no same-cycle bypass.
REQ-017 Bubbles (in_valid=0) SHALL be allowed between any inputs without disturbing the lane counter or the partial word.
REQ-018 Word order at the output SHALL equal completion order; no reordering.

Reset
REQ-019 On rst=1 the following SHALL be cleared at the next edge:
- pipeline valids, lane counter, partial word, FIFO pointers and count;
- out_valid=0, out_data=0, out_last=0, overflow=0.
REQ-020 rst mid-word or mid-pipeline SHALL discard all in-flight data; the first input after rst deasserts SHALL land in lane 0.
REQ-021 overflow SHALL clear only on rst.

Verification
REQ-022 Identity: leaky_en=0, scale=1, shift=0, zp=0; inputs 0..7 on consecutive cycles -> out_data=0x0706050403020100, out_last=0, out_valid in cycle 11 (first input in cycle 0).
REQ-023 Leaky: in=-100, leaky_en=1, scale=1, shift=0, zp=128 -> byte 0x75 (-1300>>>7 = -11, +128 = 117); in=50, same config -> 0xB2.
REQ-024 Round/clamp: scale=1, shift=1, in=3 -> 0x02; shift=0, in=1000 -> 0xFF; leaky_en=0, in=-5, zp=0 -> 0x00.
REQ-025 Partial flush: inputs 0x11,0x22,0x33 (identity config), third with in_last=1 -> out_data=0x0000000000332211, out_last=1; the next input lands in lane 0.
REQ-026 Backpressure/overflow: out_ready=0, 5 full words -> 4 stored, overflow=1, 5th lost. Then out_ready=1 -> exactly words 1..4 in order, stable while stalled.
REQ-027 Reset mid-word: 3 inputs, rst one cycle, then 8 inputs 0..7 -> single word 0x0706050403020100, overflow=0.
